// File: rtl/ysq_seq_squarer_pkg.sv
// Shared types and sizes for the sequential shift-add squarer.
package ysq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int YSQ_WIDTH = 8;
    localparam int RES_W     = 2 * YSQ_WIDTH;

endpackage

// File: rtl/ysq_seq_squarer_shift_add.sv
// Shift-add datapath: multiplicand, multiplier shift register, accumulator and
// bit counter. acc_next is the accumulator including the current bit's
// partial product, so the controller can capture the final sum on the last step.
module ysq_shift_add
    import ysq_pkg::*;
#(
    parameter int WIDTH = YSQ_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   x_in,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               last
);

    // Counter must reach WIDTH-1 without wrapping; one bit minimum for WIDTH==1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    // Partial product for the current multiplier bit, added into the running sum.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + (mcand << cnt);
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));

    // Load operand on accept, then consume one multiplier bit per step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, x_in};
            mplier <= x_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ysq_seq_squarer.sv
// Sequential squarer top: IDLE/CALC/DONE controller, held result register and
// byte-select output mux around the shift-add datapath.
module ysq_seq_squarer
    import ysq_pkg::*;
#(
    parameter int WIDTH = YSQ_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   x_in,
    input  logic               start,
    input  logic               out_sel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y,
    output logic [7:0]         y_byte
);

    state_t             state;
    logic               load;
    logic               step;
    logic               last;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH+15:0] y_ext;

    // start is only honoured in IDLE; anything arriving while busy is dropped.
    assign load = (state == IDLE) && start;
    assign step = (state == CALC);

    ysq_shift_add #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .x_in     (x_in),
        .acc_next (acc_next),
        .last     (last)
    );

    // Controller with registered busy/done; y captures the final sum on the last step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        y     <= acc_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Zero-extend so the high byte select stays legal for narrow WIDTH.
    assign y_ext  = {16'b0, y};
    assign y_byte = out_sel ? y_ext[15:8] : y_ext[7:0];

endmodule

// File: tb/tb_ysq_seq_squarer.sv
// Self-checking bench for ysq_seq_squarer: a cycle-level countdown model of
// request/result timing checked every cycle, plus directed literal checks.
module tb_ysq_seq_squarer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  x_in;
    logic        start;
    logic        out_sel;
    logic        busy;
    logic        done;
    logic [15:0] y;
    logic [7:0]  y_byte;

    int checks   = 0;
    int failures = 0;

    // Model: a request occupies 9 busy cycles; the result appears in the last.
    int          m_left  = 0;
    int          m_res   = 0;
    int          m_y     = 0;
    bit          m_valid = 1'b0;

    ysq_seq_squarer #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_in    (x_in),
        .start   (start),
        .out_sel (out_sel),
        .busy    (busy),
        .done    (done),
        .y       (y),
        .y_byte  (y_byte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Behavioural model, updated from the same sampled inputs as the DUT.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_left  = 0;
            m_y     = 0;
            m_valid = 1'b1;
        end else if (m_left == 0) begin
            if (start) begin
                m_left = 9;
                m_res  = int'(x_in) * int'(x_in);
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1) m_y = m_res;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_busy", int'(busy), (m_left > 0) ? 1 : 0);
            chk("cyc_done", int'(done), (m_left == 1) ? 1 : 0);
            chk("cyc_y", int'(y), m_y);
            chk("cyc_ybyte", int'(y_byte), out_sel ? (m_y / 256) : (m_y % 256));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bytes(input string nm, input int lo, input int hi);
        out_sel = 1'b0; #1;
        chk({nm, "_lo"}, int'(y_byte), lo);
        out_sel = 1'b1; #1;
        chk({nm, "_hi"}, int'(y_byte), hi);
        out_sel = 1'b0;
    endtask

    // Single request: edges from acceptance to done, literal result, bytes.
    task automatic run_one(input logic [7:0] xv, input int ey, input string nm);
        int n;
        x_in  = xv;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        chk({nm, "_lat"}, n, 9);
        chk({nm, "_y"}, int'(y), ey);
        check_bytes(nm, ey % 256, ey / 256);
        tick();
        chk({nm, "_idle"}, int'(busy), 0);
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) pulses++;
        end
    endtask

    initial begin
        int n;
        int p;
        rst_n   = 1'b0;
        start   = 1'b0;
        x_in    = 8'd0;
        out_sel = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_y", int'(y), 0);
        check_bytes("rst", 0, 0);

        run_one(8'd13, 169, "x13");
        chk("model_x13", m_y, 169);
        run_one(8'd255, 16'hFE01, "x255");
        chk("model_x255", m_y, 65025);
        run_one(8'd0, 0, "x0");

        // Second start during CALC must be ignored.
        x_in  = 8'd13;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        x_in  = 8'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 4;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        chk("ign_lat", n, 9);
        chk("ign_y", int'(y), 169);
        count_done(15, p);
        chk("ign_no_second", p, 0);

        // start held high: one result every 10 cycles.
        x_in  = 8'd16;
        start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 30);
        chk("held_first_lat", n, 9);
        chk("held_y256", int'(y), 256);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 30);
        chk("held_period1", n, 10);
        chk("held_y256b", int'(y), 256);
        x_in = 8'd3;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 30);
        chk("held_period2", n, 10);
        chk("held_y9", int'(y), 9);
        start = 1'b0;
        tick();
        tick();
        chk("held_idle", int'(busy), 0);

        // Reset during CALC aborts the computation.
        x_in  = 8'd255;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_y", int'(y), 0);
        count_done(12, p);
        chk("abort_no_done", p, 0);
        run_one(8'd2, 4, "x2");

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
